// File: rtl/dmem_responder_if.sv
// LSU data-port bundle between the load/store unit (master) and dmem_responder (slave).
interface dmem_responder_if;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   logic              req_valid;
   logic              req_ready;
   logic [DATA_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   logic [STRB_W-1:0] req_strobe;
   logic              req_write_en;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_data;
   logic              err_oor;

   modport master (
      output req_valid, req_addr, req_data, req_strobe, req_write_en, resp_ready,
      input  req_ready, resp_valid, resp_data, err_oor
   );

   modport slave (
      input  req_valid, req_addr, req_data, req_strobe, req_write_en, resp_ready,
      output req_ready, resp_valid, resp_data, err_oor
   );
endinterface

// File: rtl/dmem_responder.sv
// Memory-side LSU data responder: one request at a time, byte-strobed stores, valid/ready load response.
// Optional out-of-range detection enabled by defining DMEM_OOR_CHECK_EN.
module dmem_responder #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LATENCY    = 2
) (
   input  logic clk,
   input  logic rst,
   dmem_responder_if.slave bus
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

   state_e                state, stateNext;
   logic [CNT_W-1:0]      cnt, cntNext;
   logic                  accept, ramWe, capture;
   logic                  reqReady, reqReadyNext;
   logic                  respValid, respValidNext;
   logic [DATA_W-1:0]     respData;
   logic [ADDR_WIDTH-1:0] latAddr;
   logic [DATA_W-1:0]     latData;
   logic [STRB_W-1:0]     latStrobe;
   logic                  latWrite;
   logic                  rangeOk;
   logic                  unusedAddr;
   logic [DATA_W-1:0]     mem [DEPTH];

   assign bus.req_ready  = reqReady;
   assign bus.resp_valid = respValid;
   assign bus.resp_data  = respData;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   // Next-state and next-output decode
   always_comb begin
      stateNext     = state;
      cntNext       = cnt;
      accept        = 1'b0;
      ramWe         = 1'b0;
      capture       = 1'b0;
      reqReadyNext  = 1'b0;
      respValidNext = 1'b0;
      case (state)
         IDLE: begin
            // The cycle carrying the completion pulse still sees the finished request's valid.
            if (bus.req_valid && !reqReady) begin
               accept    = 1'b1;
               cntNext   = CNT_W'(LATENCY - 1);
               stateNext = BUSY;
            end
         end
         BUSY: begin
            if (!bus.req_valid) begin
               stateNext = IDLE;
            end else if (cnt != '0) begin
               cntNext = cnt - CNT_W'(1);
            end else begin
               reqReadyNext = 1'b1;
               if (latWrite) begin
                  ramWe     = rangeOk;
                  stateNext = IDLE;
               end else begin
                  capture   = 1'b1;
                  stateNext = RESP;
               end
            end
         end
         RESP: begin
            if (respValid && bus.resp_ready) stateNext = IDLE;
            else                             respValidNext = 1'b1;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Handshake outputs, latency counter and load-data capture
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         reqReady  <= 1'b0;
         respValid <= 1'b0;
         respData  <= '0;
      end else begin
         cnt       <= cntNext;
         reqReady  <= reqReadyNext;
         respValid <= respValidNext;
         if (capture) respData <= rangeOk ? mem[latAddr] : '0;
      end
   end

   // Request fields held for the whole BUSY window
   always_ff @(posedge clk) begin
      if (accept) begin
         latAddr   <= bus.req_addr[ADDR_WIDTH+1:2];
         latData   <= bus.req_data;
         latStrobe <= bus.req_strobe;
         latWrite  <= bus.req_write_en;
      end
   end

   // Byte-lane RAM write; reset on the completion edge cancels the store
   always_ff @(posedge clk) begin
      if (ramWe && !rst) begin
         for (int i = 0; i < int'(STRB_W); i++) begin
            if (latStrobe[i]) mem[latAddr][8*i +: 8] <= latData[8*i +: 8];
         end
      end
   end

`ifdef DMEM_OOR_CHECK_EN
   logic latOor;
   logic errOor;

   always_ff @(posedge clk) begin
      if (accept) latOor <= |bus.req_addr[DATA_W-1:ADDR_WIDTH+2];
   end

   // Sticky until reset; raised on completion, not on acceptance
   always_ff @(posedge clk) begin
      if (rst)                          errOor <= 1'b0;
      else if (reqReadyNext && latOor)  errOor <= 1'b1;
   end

   assign rangeOk     = !latOor;
   assign bus.err_oor = errOor;
   assign unusedAddr  = ^bus.req_addr[1:0];
`else
   assign rangeOk     = 1'b1;
   assign bus.err_oor = 1'b0;
   assign unusedAddr  = ^{bus.req_addr[DATA_W-1:ADDR_WIDTH+2], bus.req_addr[1:0]};
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder (LATENCY=2, ADDR_WIDTH=10).
module tb_dmem_responder;
   localparam int unsigned ADDR_WIDTH = 10;
   localparam int unsigned LATENCY    = 2;
   localparam int unsigned NVEC       = 14;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
   } vec_t;

   logic clk;
   logic rst;
   int   compared;
   int   mismatched;
   vec_t vecs [NVEC];

   dmem_responder_if bus ();

   dmem_responder #(.ADDR_WIDTH(ADDR_WIDTH), .LATENCY(LATENCY)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb);
      bus.req_valid    = 1'b1;
      bus.req_write_en = wr;
      bus.req_addr     = addr;
      bus.req_data     = data;
      bus.req_strobe   = strb;
   endtask

   // Drive until req_ready; returns number of cycles waited (20 on timeout)
   task automatic waitReady(output int waited);
      waited = 0;
      while (waited < 20) begin
         step();
         waited++;
         if (bus.req_ready === 1'b1) break;
      end
   endtask

   task automatic doReq(input string name, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input logic [31:0] exp);
      int waited;
      drive(wr, addr, data, strb);
      waitReady(waited);
      check({name, " latency"}, 32'(waited), 32'(LATENCY + 1));
      check({name, " resp_valid with ready"}, 32'(bus.resp_valid), 32'(0));
      bus.req_valid = 1'b0;
      step();
      check({name, " ready pulse"}, 32'(bus.req_ready), 32'(0));
      if (wr) begin
         check({name, " store no resp"}, 32'(bus.resp_valid), 32'(0));
      end else begin
         check({name, " resp_valid"}, 32'(bus.resp_valid), 32'(1));
         check({name, " resp_data"}, bus.resp_data, exp);
         bus.resp_ready = 1'b1;
         step();
         bus.resp_ready = 1'b0;
         check({name, " resp drop"}, 32'(bus.resp_valid), 32'(0));
      end
   endtask

   initial begin
      int waited;
      compared   = 0;
      mismatched = 0;

      vecs[0]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'b1111, 32'h0};
      vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'h1122_3344};
      vecs[2]  = '{1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 4'b1111, 32'h0};
      vecs[3]  = '{1'b1, 32'h0000_0008, 32'h0000_AB00, 4'b0010, 32'h0};
      vecs[4]  = '{1'b0, 32'h0000_0008, 32'h0,         4'b0000, 32'hFFFF_ABFF};
      vecs[5]  = '{1'b1, 32'h0000_0008, 32'h1234_5678, 4'b0000, 32'h0};
      vecs[6]  = '{1'b0, 32'h0000_0008, 32'h0,         4'b0000, 32'hFFFF_ABFF};
      vecs[7]  = '{1'b1, 32'h0000_000C, 32'h0000_0000, 4'b1111, 32'h0};
      vecs[8]  = '{1'b1, 32'h0000_000C, 32'hA5A5_A5A5, 4'b1001, 32'h0};
      vecs[9]  = '{1'b0, 32'h0000_000C, 32'h0,         4'b0000, 32'hA500_00A5};
      vecs[10] = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'b1111, 32'h0};
      vecs[11] = '{1'b0, 32'h0000_0003, 32'h0,         4'b0000, 32'hCAFE_F00D};
      vecs[12] = '{1'b1, 32'h0000_0024, 32'hBEEF_0024, 4'b1111, 32'h0};
      vecs[13] = '{1'b1, 32'h0000_0004, 32'h0BAD_C0DE, 4'b1111, 32'h0};

      rst              = 1'b1;
      bus.req_valid    = 1'b0;
      bus.req_write_en = 1'b0;
      bus.req_addr     = '0;
      bus.req_data     = '0;
      bus.req_strobe   = '0;
      bus.resp_ready   = 1'b0;
      step();
      step();
      check("reset req_ready",  32'(bus.req_ready),  32'(0));
      check("reset resp_valid", 32'(bus.resp_valid), 32'(0));
      check("reset resp_data",  bus.resp_data,       32'h0);
      check("reset err_oor",    32'(bus.err_oor),    32'(0));
      rst = 1'b0;
      step();

      for (int i = 0; i < int'(NVEC); i++) begin
         doReq($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data,
               vecs[i].strb, vecs[i].exp);
      end

      // Response stall: data must hold while resp_ready stays low
      drive(1'b0, 32'h0000_0010, 32'h0, 4'b0000);
      waitReady(waited);
      check("stall latency", 32'(waited), 32'(LATENCY + 1));
      bus.req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("stall valid %0d", i), 32'(bus.resp_valid), 32'(1));
         check($sformatf("stall data %0d", i), bus.resp_data, 32'h1122_3344);
      end
      bus.resp_ready = 1'b1;
      step();
      bus.resp_ready = 1'b0;
      check("stall drop", 32'(bus.resp_valid), 32'(0));

      // Flush: req_valid withdrawn after one cycle abandons the load
      drive(1'b0, 32'h0000_0020, 32'h0, 4'b0000);
      step();
      bus.req_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("flush ready %0d", i), 32'(bus.req_ready), 32'(0));
         check($sformatf("flush resp %0d", i), 32'(bus.resp_valid), 32'(0));
      end
      doReq("after flush", 1'b0, 32'h0000_0024, 32'h0, 4'b0000, 32'hBEEF_0024);

      // Reset on the completion edge of a store cancels it
      drive(1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'b1111);
      step();
      step();
      rst = 1'b1;
      step();
      check("rst req_ready",  32'(bus.req_ready),  32'(0));
      check("rst resp_valid", 32'(bus.resp_valid), 32'(0));
      check("rst resp_data",  bus.resp_data,       32'h0);
      check("rst err_oor",    32'(bus.err_oor),    32'(0));
      rst = 1'b0;
      bus.req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("post rst ready %0d", i), 32'(bus.req_ready), 32'(0));
      end
      doReq("word1 intact", 1'b0, 32'h0000_0004, 32'h0, 4'b0000, 32'h0BAD_C0DE);

      // Upper address bits: flagged with the check enabled, aliased otherwise
`ifdef DMEM_OOR_CHECK_EN
      doReq("oor load", 1'b0, 32'h0000_1000, 32'h0, 4'b0000, 32'h0);
      check("oor flag", 32'(bus.err_oor), 32'(1));
      doReq("oor store", 1'b1, 32'h0000_1000, 32'h9999_9999, 4'b1111, 32'h0);
      doReq("oor word0", 1'b0, 32'h0000_0000, 32'h0, 4'b0000, 32'hCAFE_F00D);
      check("oor sticky", 32'(bus.err_oor), 32'(1));
`else
      doReq("alias load", 1'b0, 32'h0000_1000, 32'h0, 4'b0000, 32'hCAFE_F00D);
      check("alias flag", 32'(bus.err_oor), 32'(0));
      doReq("alias store", 1'b1, 32'h0000_1000, 32'h9999_9999, 4'b1111, 32'h0);
      doReq("alias word0", 1'b0, 32'h0000_0000, 32'h0, 4'b0000, 32'h9999_9999);
      check("alias sticky", 32'(bus.err_oor), 32'(0));
`endif
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("flag cleared", 32'(bus.err_oor), 32'(0));
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
